// File: rtl/iir_out_fifo_if.sv
// Handshake bundle between the IIR filter/consumer and the output FIFO.
// The drop-counter lane exists only when IIR_FIFO_DROPCNT_EN is defined.
interface iir_out_fifo_if #(
    parameter int NB    = 8,
    parameter int DEPTH = 8
);
    logic                      vin;
    logic [NB-1:0]             din;
    logic                      ready;
    logic                      clr_ovf;
    logic                      vout;
    logic [NB-1:0]             dout;
    logic [$clog2(DEPTH):0]    count;
    logic                      full;
    logic                      empty;
    logic                      ovf;
`ifdef IIR_FIFO_DROPCNT_EN
    logic [15:0]               drop_cnt;

    modport slave  (input  vin, din, ready, clr_ovf,
                    output vout, dout, count, full, empty, ovf, drop_cnt);
    modport master (output vin, din, ready, clr_ovf,
                    input  vout, dout, count, full, empty, ovf, drop_cnt);
`else
    modport slave  (input  vin, din, ready, clr_ovf,
                    output vout, dout, count, full, empty, ovf);
    modport master (output vin, din, ready, clr_ovf,
                    input  vout, dout, count, full, empty, ovf);
`endif
endinterface

// File: rtl/iir_out_fifo.sv
// First-word-fall-through output FIFO behind the IIR filter; drops and flags
// overflow instead of stalling. IIR_FIFO_DROPCNT_EN adds a saturating drop counter.
module iir_out_fifo #(
    parameter int NB    = 8,
    parameter int DEPTH = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    iir_out_fifo_if.slave   s_if
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [NB-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full, r_empty, r_ovf;

    logic          w_rd, w_wr, w_drop;
    logic [CW-1:0] w_count_nxt;

    // A read in the same cycle frees a slot, so a full FIFO still accepts the write.
    assign w_rd   = !r_empty && s_if.ready;
    assign w_wr   = s_if.vin && (!r_full || w_rd);
    assign w_drop = s_if.vin && r_full && !w_rd;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_rd)
            w_count_nxt = r_count + 1'b1;
        else if (w_rd && !w_wr)
            w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
            r_empty <= (w_count_nxt == '0);
            if (w_drop)
                r_ovf <= 1'b1;
            else if (s_if.clr_ovf)
                r_ovf <= 1'b0;
        end
    end

    // Storage is deliberately not reset; the empty gate on dout hides stale words.
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= s_if.din;
    end

`ifdef IIR_FIFO_DROPCNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_drop_cnt <= '0;
        else if (w_drop) begin
            if (s_if.clr_ovf)
                r_drop_cnt <= 16'd1;
            else if (r_drop_cnt != 16'hFFFF)
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end else if (s_if.clr_ovf)
            r_drop_cnt <= '0;
    end

    assign s_if.drop_cnt = r_drop_cnt;
`endif

    assign s_if.vout  = !r_empty;
    assign s_if.dout  = r_empty ? '0 : r_mem[r_rd_ptr];
    assign s_if.count = r_count;
    assign s_if.full  = r_full;
    assign s_if.empty = r_empty;
    assign s_if.ovf   = r_ovf;
endmodule

// File: tb/tb_iir_out_fifo.sv
// Randomized + directed bench for iir_out_fifo against a queue-based reference model.
module tb_iir_out_fifo;
    localparam int NB    = 8;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    iir_out_fifo_if #(.NB(NB), .DEPTH(DEPTH)) f_if ();

    iir_out_fifo #(.NB(NB), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .s_if    (f_if)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [NB-1:0] mq [$];
    bit            m_ovf;
    int            m_dc;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".vout"},  32'(f_if.vout),  32'(mq.size() > 0));
        chk({tag, ".dout"},  32'(f_if.dout),  (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
        chk({tag, ".count"}, 32'(f_if.count), 32'(mq.size()));
        chk({tag, ".full"},  32'(f_if.full),  32'(mq.size() == DEPTH));
        chk({tag, ".empty"}, 32'(f_if.empty), 32'(mq.size() == 0));
        chk({tag, ".ovf"},   32'(f_if.ovf),   32'(m_ovf));
`ifdef IIR_FIFO_DROPCNT_EN
        chk({tag, ".dcnt"},  32'(f_if.drop_cnt), 32'(m_dc));
`endif
    endtask

    // One clock: drive at negedge, update the model at posedge, check #1 later.
    task automatic step(input string tag, input bit vin, input logic [NB-1:0] din,
                        input bit ready, input bit clr);
        bit rd, drop, was_full;
        @(negedge clk);
        f_if.vin = vin; f_if.din = din; f_if.ready = ready; f_if.clr_ovf = clr;
        @(posedge clk);
        was_full = (mq.size() == DEPTH);
        rd   = (mq.size() > 0) && ready;
        drop = vin && was_full && !rd;
        if (rd) void'(mq.pop_front());
        if (vin && !drop) mq.push_back(din);
        if (drop) begin
            m_ovf = 1'b1;
            m_dc  = clr ? 1 : ((m_dc < 65535) ? m_dc + 1 : 65535);
        end else if (clr) begin
            m_ovf = 1'b0;
            m_dc  = 0;
        end
        #1;
        chk_all(tag);
    endtask

    // Asserts reset right now (between edges) and checks it takes effect at once.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        mq.delete(); m_ovf = 1'b0; m_dc = 0;
        #1;
        chk_all(tag);
        @(negedge clk);
        f_if.vin = 1'b0; f_if.ready = 1'b0; f_if.clr_ovf = 1'b0; f_if.din = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        f_if.vin = 1'b0; f_if.din = '0; f_if.ready = 1'b0; f_if.clr_ovf = 1'b0;
        mq.delete(); m_ovf = 1'b0; m_dc = 0;
        #12;
        chk_all("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // single write, first-word fall-through one cycle later
        step("one", 1'b1, 8'h35, 1'b0, 1'b0);
        chk("one.dout35", 32'(f_if.dout), 32'h35);
        step("one_rd", 1'b0, 8'h00, 1'b1, 1'b0);

        // fill to full, then drain in order
        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill.full", 32'(f_if.full), 32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            chk("drain.order", 32'(f_if.dout), 32'(i));
            step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain.empty", 32'(f_if.empty), 32'd1);

        // drop on full, then write-through-read on full
        for (int i = 1; i <= DEPTH; i++) step("fill2", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step("drop", 1'b1, 8'hAA, 1'b0, 1'b0);
        chk("drop.ovf", 32'(f_if.ovf), 32'd1);
        step("fullrw", 1'b1, 8'hAA, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
        step("clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // streaming from empty
        for (int i = 0; i < 20; i++) step("stream", 1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++)  step("stream_end", 1'b0, 8'h00, 1'b1, 1'b0);

        // async reset with 5 stored
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        @(negedge clk);
        #2;
        async_reset("midrst");
        step("post_rst", 1'b1, 8'h77, 1'b0, 1'b0);
        chk("post_rst.dout", 32'(f_if.dout), 32'h77);
        step("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);

        // drop counting vs clear
        for (int i = 0; i < DEPTH; i++) step("fill3", 1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)     step("drop3", 1'b1, 8'hEE, 1'b0, 1'b0);
        step("drop_clr", 1'b1, 8'hEE, 1'b0, 1'b1);
        chk("drop_clr.ovf", 32'(f_if.ovf), 32'd1);
        step("clr_only", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_only.ovf", 32'(f_if.ovf), 32'd0);

        // random traffic
        for (int i = 0; i < 400; i++)
            step("rand", ($urandom_range(0, 99) < 65), 8'($urandom),
                 ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 4));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
